// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Loads a program into the 16-bit instruction memory from a byte stream.
// Bytes arrive high byte first over a valid/ready handshake. Every pair of
// bytes becomes one instruction word, written to consecutive word addresses
// starting at base_addr. Addresses wrap modulo 2^ADDR_W.
//
// Parameters
//   ADDR_W       instruction memory address width
//   TIMEOUT      number of stall cycles allowed while waiting for a byte
//                before the session aborts; 0 disables the timeout
//
// Ports
//   clk          clock; all state changes happen on the rising edge
//   rst_n        asynchronous active-low reset
//   start        begins a session; sampled only while idle
//   base_addr    first word address, latched on start
//   word_count   number of words to load, latched on start; 0 means 2^ADDR_W
//   byte_in      stream byte
//   byte_valid   byte_in is valid; the source holds it until it is accepted
//   byte_ready   the loader accepts a byte this cycle
//   imem_wr      instruction memory write strobe, one cycle per word
//   imem_addr    write address; holds the current word address at all times
//   imem_data    write data, {high byte, low byte}
//   busy         a session is active; the core stays stalled while it is high
//   done         one-cycle pulse after the last word has been written
//   timeout_err  sticky abort flag; cleared by the next accepted start
//   checksum     modulo-256 sum of all accepted bytes; held until next start
// -----------------------------------------------------------------------------
module prog_loader #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_wr,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_data,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [7:0]        checksum
);

   // Wide enough to hold TIMEOUT; at least one bit when the timeout is off.
   localparam int CNT_W = $clog2(TIMEOUT + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WR,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] remain_q;
   logic [15:0]       data_q;
   logic [CNT_W-1:0]  stall_cnt;
   logic              accept;
   logic              stall_hit;

   assign byte_ready = (state == S_HI) || (state == S_LO);
   assign busy       = (state == S_HI) || (state == S_LO) || (state == S_WR);
   assign accept     = byte_valid && byte_ready;
   assign imem_addr  = addr_q;
   assign imem_data  = data_q;

   // The cycle that would take the stall count to TIMEOUT aborts the session.
   assign stall_hit = (TIMEOUT != 0) && (stall_cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the values that were present before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement leaves one unassigned and infers a latch.
   always_comb begin
      state_nx = state;
      imem_wr  = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_HI;
         end
         S_HI: begin
            if (accept)         state_nx = S_LO;
            else if (stall_hit) state_nx = S_IDLE;
         end
         S_LO: begin
            if (accept)         state_nx = S_WR;
            else if (stall_hit) state_nx = S_IDLE;
         end
         S_WR: begin
            imem_wr  = 1'b1;
            // remain_q starts at 0 for a full-memory load; it then wraps on the
            // first decrement and only the final word sees a count of 1.
            state_nx = (remain_q == ADDR_W'(1)) ? S_DONE : S_HI;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         remain_q    <= '0;
         data_q      <= '0;
         stall_cnt   <= '0;
         checksum    <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q      <= base_addr;
                  remain_q    <= word_count;
                  stall_cnt   <= '0;
                  checksum    <= '0;
                  timeout_err <= 1'b0;
               end
            end
            S_HI, S_LO: begin
               if (accept) begin
                  stall_cnt <= '0;
                  checksum  <= checksum + byte_in;
                  if (state == S_HI) data_q[15:8] <= byte_in;
                  else               data_q[7:0]  <= byte_in;
               end else if (stall_hit) begin
                  stall_cnt   <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + CNT_W'(1);
               end
            end
            S_WR: begin
               addr_q   <= addr_q + ADDR_W'(1);
               remain_q <= remain_q - ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
